// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: memory map defaults,
// the NOP encoding and the fetch-queue entry layout.
package ifu_fetch_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IFU_IM_BASE  = 32'h0000_3000;
  localparam int          IFU_IM_WORDS = 4096;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_queue.sv
// Two-entry circular fetch queue with synchronous flush; the flush overrides
// any push or pop issued in the same cycle.
module fetch_queue
  import ifu_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [1:0]   count,
  output logic         empty
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;
  assign empty   = (count == 2'd0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Entry storage is data only; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch initiator: sequential PC, single outstanding request to a
// synchronous-read instruction memory, range/alignment checking and redirects.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter logic [31:0] IM_BASE  = IFU_IM_BASE,
  parameter int          IM_WORDS = IFU_IM_WORDS,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_err
);

  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < IM_BASE) || ({1'b0, a} >= IM_LIMIT);
  endfunction

  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic [31:0]  fetch_pc;
  logic [31:0]  req_pc;
  logic         req_err;
  logic         inflight;
  logic         cur_err;
  logic         issue;
  logic         push;
  logic         pop;
  logic         q_empty;
  logic [1:0]   count;
  logic [2:0]   occ;

  // Issue only when the returning word is certain to find a free slot.
  assign pop      = out_valid && out_ready;
  assign occ      = {1'b0, count} + {2'b00, inflight} + {2'b00, ~pop};
  assign issue    = reset && !redirect && (occ <= 3'(DEPTH));
  assign cur_err  = addr_err(fetch_pc);
  assign im_req   = issue && !cur_err;
  assign im_addr  = fetch_pc;

  // A response returning in a redirect cycle is stale and is discarded.
  assign push             = inflight && !redirect;
  assign push_entry.pc    = req_pc;
  assign push_entry.instr = req_err ? NOP : im_rdata;
  assign push_entry.err   = req_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) fetch_pc <= fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      req_pc  <= fetch_pc;
      req_err <= cur_err;
    end
  end

  fetch_queue u_queue (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .count (count),
    .empty (q_empty)
  );

  assign out_valid = !q_empty;
  assign out_pc    = out_valid ? head.pc    : 32'd0;
  assign out_instr = out_valid ? head.instr : 32'd0;
  assign out_err   = out_valid && head.err;

endmodule
